// File: rtl/fetch_sequencer.sv
// Run-control sequencer for the fetch unit: launch, halt/resume, and resolution of
// branch/call/return into a single zero-latency jump, backed by a return-address stack.
module fetch_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              go_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              halt_req_i,
  input  logic              branch_i,
  input  logic              branch_taken_i,
  input  logic              call_i,
  input  logic              ret_i,
  input  logic [ADDR_W-1:0] target_i,
  input  logic              resume_i,
  output logic              start_o,
  output logic [ADDR_W-1:0] start_addr_o,
  output logic              halt_o,
  output logic              yes_jump_o,
  output logic [ADDR_W-1:0] target_o,
  output logic [2:0]        state_o,
  output logic              stack_err_o,
  output logic [15:0]       cycle_cnt_o
);
  localparam int SP_W = $clog2(STACK_DEPTH) + 1;
  localparam int IX_W = SP_W - 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_HALTED = 3'd3;
  localparam logic [2:0] S_FAULT  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              err_q, err_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] saddr_q, saddr_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic              push;
  logic              full, empty;
  logic [IX_W-1:0]   push_idx, pop_idx;
  logic [SP_W-1:0]   sp_m1;

  assign full     = (sp_q == SP_W'(STACK_DEPTH));
  assign empty    = (sp_q == '0);
  assign sp_m1    = sp_q - 1'b1;
  assign push_idx = sp_q[IX_W-1:0];
  assign pop_idx  = sp_m1[IX_W-1:0];

  always_comb begin
    state_d    = state_q;
    sp_d       = sp_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    saddr_d    = saddr_q;
    push       = 1'b0;
    start_o    = 1'b0;
    halt_o     = 1'b1;
    yes_jump_o = 1'b0;
    target_o   = target_i;
    case (state_q)
      S_IDLE: begin
        if (go_i) begin
          saddr_d = start_addr_i;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        start_o = 1'b1;
        halt_o  = 1'b0;
        sp_d    = '0;
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = S_RUN;
      end
      S_RUN: begin
        halt_o = 1'b0;
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        // Fixed priority: halt > ret > call > branch
        if (halt_req_i) begin
          halt_o  = 1'b1;
          state_d = S_HALTED;
        end else if (ret_i) begin
          if (!empty) begin
            yes_jump_o = 1'b1;
            target_o   = stack_q[pop_idx];
            sp_d       = sp_m1;
          end else begin
            err_d   = 1'b1;
            state_d = S_FAULT;
          end
        end else if (call_i) begin
          if (!full) begin
            yes_jump_o = 1'b1;
            push       = 1'b1;
            sp_d       = sp_q + 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = S_FAULT;
          end
        end else if (branch_i && branch_taken_i) begin
          yes_jump_o = 1'b1;
        end
      end
      S_HALTED: begin
        if (go_i) begin
          saddr_d = start_addr_i;
          state_d = S_LAUNCH;
        end else if (resume_i) begin
          state_d = S_RUN;
        end
      end
      S_FAULT: begin
        if (go_i) begin
          saddr_d = start_addr_i;
          state_d = S_LAUNCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      sp_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      saddr_q <= '0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      saddr_q <= saddr_d;
    end
  end

  // Stack storage needs no reset; sp alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push && !reset_i) stack_q[push_idx] <= pc_i + ADDR_W'(1);
  end

  assign state_o      = state_q;
  assign stack_err_o  = err_q;
  assign cycle_cnt_o  = cnt_q;
  assign start_addr_o = saddr_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus random traffic, checked against
// a queue-based behavioural model of the run-control rules.
module tb_fetch_sequencer;
  logic       clk = 1'b0;
  logic       reset_i, go_i, halt_req_i, branch_i, branch_taken_i, call_i, ret_i, resume_i;
  logic [7:0] start_addr_i, pc_i, target_i;
  logic       start_o, halt_o, yes_jump_o, stack_err_o;
  logic [7:0] start_addr_o, target_o;
  logic [2:0] state_o;
  logic [15:0] cycle_cnt_o;

  int tests = 0;
  int fails = 0;

  // model state
  int         m_state = 0;
  logic [7:0] m_stk[$];
  bit         m_err = 0;
  int         m_cnt = 0;
  logic [7:0] m_saddr = 0;

  fetch_sequencer #(.ADDR_W(8), .STACK_DEPTH(4)) dut (
    .clk(clk), .reset_i(reset_i), .go_i(go_i), .start_addr_i(start_addr_i), .pc_i(pc_i),
    .halt_req_i(halt_req_i), .branch_i(branch_i), .branch_taken_i(branch_taken_i),
    .call_i(call_i), .ret_i(ret_i), .target_i(target_i), .resume_i(resume_i),
    .start_o(start_o), .start_addr_o(start_addr_o), .halt_o(halt_o), .yes_jump_o(yes_jump_o),
    .target_o(target_o), .state_o(state_o), .stack_err_o(stack_err_o), .cycle_cnt_o(cycle_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic clr();
    reset_i = 0; go_i = 0; halt_req_i = 0; branch_i = 0; branch_taken_i = 0;
    call_i = 0; ret_i = 0; resume_i = 0; start_addr_i = 0; pc_i = 0; target_i = 0;
  endtask

  // Called at a negedge with inputs already driven; checks, then advances one clock.
  task automatic step(input bit do_chk);
    bit         e_jump, e_halt;
    logic [7:0] e_tgt;
    int         n_state, n_cnt;
    bit         n_err, do_push, do_pop, do_clear;
    logic [7:0] n_saddr;
    #2;
    e_jump = 0; e_tgt = target_i;
    e_halt = (m_state != 1) && (m_state != 2 || halt_req_i);
    n_state = m_state; n_cnt = m_cnt; n_err = m_err; n_saddr = m_saddr;
    do_push = 0; do_pop = 0; do_clear = 0;
    case (m_state)
      0: if (go_i) begin n_saddr = start_addr_i; n_state = 1; end
      1: begin do_clear = 1; n_cnt = 0; n_err = 0; n_state = 2; end
      2: begin
        n_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        if (halt_req_i) n_state = 3;
        else if (ret_i) begin
          if (m_stk.size() > 0) begin e_jump = 1; e_tgt = m_stk[$]; do_pop = 1; end
          else begin n_state = 4; n_err = 1; end
        end else if (call_i) begin
          if (m_stk.size() < 4) begin e_jump = 1; do_push = 1; end
          else begin n_state = 4; n_err = 1; end
        end else if (branch_i && branch_taken_i) e_jump = 1;
      end
      3: if (go_i) begin n_saddr = start_addr_i; n_state = 1; end
         else if (resume_i) n_state = 2;
      default: if (go_i) begin n_saddr = start_addr_i; n_state = 1; end
    endcase
    if (do_chk) begin
      chk("state", state_o, m_state);
      chk("start", start_o, m_state == 1);
      chk("halt", halt_o, e_halt);
      chk("jump", yes_jump_o, e_jump);
      chk("target", target_o, e_tgt);
      chk("stack_err", stack_err_o, m_err);
      chk("cycle_cnt", cycle_cnt_o, m_cnt);
      chk("start_addr", start_addr_o, m_saddr);
    end
    @(posedge clk);
    if (reset_i) begin
      m_state = 0; m_cnt = 0; m_err = 0; m_saddr = 0; m_stk.delete();
    end else begin
      m_state = n_state; m_cnt = n_cnt; m_err = n_err; m_saddr = n_saddr;
      if (do_clear) m_stk.delete();
      if (do_pop) void'(m_stk.pop_back());
      if (do_push) m_stk.push_back(pc_i + 8'd1);
    end
    @(negedge clk);
  endtask

  initial begin
    clr();
    @(negedge clk);
    reset_i = 1; step(0);            // DUT state unknown before first reset edge
    step(1);
    chk("rst_state", state_o, 0);
    chk("rst_halt", halt_o, 1);
    reset_i = 0;

    // launch at 0x20
    go_i = 1; start_addr_i = 8'h20; step(1);
    clr(); #1 chk("launch_start", start_o, 1); chk("launch_saddr", start_addr_o, 8'h20);
    #1 step(1);
    step(1);

    // call then return
    pc_i = 8'h25; call_i = 1; target_i = 8'h40; step(1);
    clr(); pc_i = 8'h40; step(1);
    ret_i = 1; target_i = 8'h99; #2 chk("ret_tgt", target_o, 8'h26); step(1);

    // five nested calls -> overflow
    clr();
    for (int i = 0; i < 5; i++) begin
      call_i = 1; pc_i = 8'h50 + 8'(i); target_i = 8'h60 + 8'(i); step(1);
    end
    clr(); #1 chk("ovf_state", state_o, 4); chk("ovf_err", stack_err_o, 1);
    #1 resume_i = 1; step(1); step(1);
    clr(); go_i = 1; start_addr_i = 8'h33; step(1);
    clr(); step(1); step(1);
    chk("relaunch_err", stack_err_o, 0);

    // underflow
    ret_i = 1; step(1);
    clr(); step(1);
    go_i = 1; start_addr_i = 8'h10; step(1); clr(); step(1); step(1);

    // halt with call, then resume
    call_i = 1; pc_i = 8'h70; target_i = 8'h80; step(1);
    halt_req_i = 1; call_i = 1; pc_i = 8'h80; target_i = 8'h90; step(1);
    clr(); step(1); step(1);
    resume_i = 1; step(1);
    clr(); ret_i = 1; target_i = 8'h00; #2 chk("halt_ret_tgt", target_o, 8'h71); step(1);

    // wrap of return address, untaken branch
    clr(); call_i = 1; pc_i = 8'hFF; target_i = 8'h05; step(1);
    clr(); ret_i = 1; step(1);
    clr(); branch_i = 1; branch_taken_i = 0; target_i = 8'hAB; step(1);
    branch_taken_i = 1; step(1);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      reset_i        = ($urandom % 100) == 0;
      go_i           = ($urandom % 8) == 0;
      halt_req_i     = ($urandom % 16) == 0;
      ret_i          = ($urandom % 5) == 0;
      call_i         = ($urandom % 4) == 0;
      branch_i       = ($urandom % 3) == 0;
      branch_taken_i = $urandom % 2;
      resume_i       = ($urandom % 4) == 0;
      start_addr_i   = 8'($urandom);
      pc_i           = 8'($urandom);
      target_i       = 8'($urandom);
      step(1);
    end

    // counter saturation: long idle RUN stretch
    clr(); reset_i = 1; step(1);
    clr(); go_i = 1; step(1); clr(); step(1);
    for (int n = 0; n < 65600; n++) step((n % 4096) == 0 || n > 65530);
    chk("cnt_sat", cycle_cnt_o, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
